// File: rtl/settle_monitor.sv
// settle_monitor: reports when a sampled signal settles inside a tolerance band around a target.
// Optional peak tracking of v_in is enabled by defining SETTLE_MONITOR_PEAK_EN.
module settle_monitor #(
    parameter int WIDTH      = 25,
    parameter int HOLD       = 8,
    parameter int MAX_CYCLES = 4096,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     v_in,
    input  logic [WIDTH-1:0]     v_target,
    input  logic [WIDTH-1:0]     v_tol,
    output logic                 busy,
    output logic                 settled,
    output logic                 timeout,
    output logic [CNT_WIDTH-1:0] settle_cycles,
    output logic [WIDTH-1:0]     v_max,
    output logic [WIDTH-1:0]     v_min
);
    typedef enum logic [1:0] {IDLE, TRACK, SETTLED, TIMEOUT} state_t;
    state_t state_q, state_d;
    logic busy_q, busy_d, settled_q, settled_d, timeout_q, timeout_d;
    logic [CNT_WIDTH-1:0] elapsed_q, elapsed_d, run_q, run_d, run_start_q, run_start_d;
    logic [CNT_WIDTH-1:0] settle_cycles_q, settle_cycles_d, run_next;
    logic [WIDTH:0] err, abs_err;
    logic in_band;
    // One extra bit keeps the difference of two signed samples from overflowing.
    assign err      = {v_in[WIDTH-1], v_in} - {v_target[WIDTH-1], v_target};
    assign abs_err  = err[WIDTH] ? -err : err;
    assign in_band  = abs_err <= {1'b0, v_tol};
    assign run_next = in_band ? run_q + 1'b1 : '0;
    always_comb begin
        state_d         = state_q;
        busy_d          = busy_q;
        settled_d       = settled_q;
        timeout_d       = timeout_q;
        elapsed_d       = elapsed_q;
        run_d           = run_q;
        run_start_d     = run_start_q;
        settle_cycles_d = settle_cycles_q;
        if (start) begin
            state_d         = TRACK;
            busy_d          = 1'b1;
            settled_d       = 1'b0;
            timeout_d       = 1'b0;
            elapsed_d       = '0;
            run_d           = '0;
            settle_cycles_d = '0;
        end else if (state_q == TRACK) begin
            elapsed_d   = elapsed_q + 1'b1;
            run_d       = run_next;
            run_start_d = (in_band && run_q == '0) ? elapsed_q : run_start_q;
            // Settling takes priority over a timeout on the same sample.
            if (run_next == CNT_WIDTH'(HOLD)) begin
                state_d         = SETTLED;
                busy_d          = 1'b0;
                settled_d       = 1'b1;
                settle_cycles_d = run_start_d;
            end else if (elapsed_q == CNT_WIDTH'(MAX_CYCLES - 1)) begin
                state_d   = TIMEOUT;
                busy_d    = 1'b0;
                timeout_d = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            busy_q          <= 1'b0;
            settled_q       <= 1'b0;
            timeout_q       <= 1'b0;
            elapsed_q       <= '0;
            run_q           <= '0;
            run_start_q     <= '0;
            settle_cycles_q <= '0;
        end else begin
            state_q         <= state_d;
            busy_q          <= busy_d;
            settled_q       <= settled_d;
            timeout_q       <= timeout_d;
            elapsed_q       <= elapsed_d;
            run_q           <= run_d;
            run_start_q     <= run_start_d;
            settle_cycles_q <= settle_cycles_d;
        end
    end
    assign busy          = busy_q;
    assign settled       = settled_q;
    assign timeout       = timeout_q;
    assign settle_cycles = settle_cycles_q;
`ifdef SETTLE_MONITOR_PEAK_EN
    logic signed [WIDTH-1:0] v_max_q, v_max_d, v_min_q, v_min_d;
    always_comb begin
        v_max_d = v_max_q;
        v_min_d = v_min_q;
        if (start) begin
            v_max_d = '0;
            v_min_d = '0;
        end else if (state_q == TRACK) begin
            v_max_d = (elapsed_q == '0 || $signed(v_in) > v_max_q) ? $signed(v_in) : v_max_q;
            v_min_d = (elapsed_q == '0 || $signed(v_in) < v_min_q) ? $signed(v_in) : v_min_q;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            v_max_q <= '0;
            v_min_q <= '0;
        end else begin
            v_max_q <= v_max_d;
            v_min_q <= v_min_d;
        end
    end
    assign v_max = v_max_q;
    assign v_min = v_min_q;
`else
    assign v_max = '0;
    assign v_min = '0;
`endif
endmodule
